// File: rtl/uart_tx_sched.sv
// Transmit scheduler for the UART: a circular byte FIFO feeding the transmitter
// core, plus the programmable baud tick generator.
module uart_tx_sched #(
   parameter int DEPTH = 16,
   parameter int DIV_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [7:0]                 wr_data,
   input  logic                       fifo_clr,
   input  logic [DIV_W-1:0]           divisor,
   input  logic                       div_ld,
   input  logic                       pop,
   input  logic                       sreg_empty,
   output logic [7:0]                 din,
   output logic                       thre,
   output logic                       baud_pulse,
   output logic                       temt,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       ovf,
   output logic                       thre_int
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

   logic [7:0]       mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count_q;
   logic [DIV_W-1:0] bcnt;
   logic             push;
   logic             pop_ok;

   assign thre   = (count_q == '0);
   assign full   = (count_q == FULL_CNT);
   assign count  = count_q;
   assign temt   = thre & sreg_empty;
   assign push   = wr_en & ~full;
   assign pop_ok = pop & ~thre;
   assign din    = thre ? 8'h00 : mem[rd_ptr];

   // Storage has no reset; stale entries are masked by count.
   always_ff @(posedge clk) begin
      if (push && !fifo_clr)
         mem[wr_ptr] <= wr_data;
   end

   // Pointers, occupancy and status flags; a flush wins over any push or pop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count_q  <= '0;
         ovf      <= 1'b0;
         thre_int <= 1'b0;
      end else if (fifo_clr) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count_q  <= '0;
         ovf      <= 1'b0;
         thre_int <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)
            rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop_ok)
            count_q <= count_q + ONE_CNT;
         else if (pop_ok && !push)
            count_q <= count_q - ONE_CNT;
         if (wr_en && full)
            ovf <= 1'b1;
         thre_int <= pop_ok & ~push & (count_q == ONE_CNT);
      end
   end

   // Baud down-counter; a zero divisor freezes it with the tick held low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bcnt       <= '0;
         baud_pulse <= 1'b0;
      end else if (divisor == '0) begin
         baud_pulse <= 1'b0;
      end else if (div_ld) begin
         bcnt       <= divisor;
         baud_pulse <= 1'b0;
      end else if (bcnt <= DIV_W'(1)) begin
         bcnt       <= divisor;
         baud_pulse <= 1'b1;
      end else begin
         bcnt       <= bcnt - DIV_W'(1);
         baud_pulse <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: accepted writes feed an expected-byte queue that a
// monitor drains on every effective pop; flags and baud ticks are checked directly.
module tb_uart_tx_sched;

   localparam int DEPTH = 16;
   localparam int DIV_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             wr_en;
   logic [7:0]       wr_data;
   logic             fifo_clr;
   logic [DIV_W-1:0] divisor;
   logic             div_ld;
   logic             pop;
   logic             sreg_empty;
   logic [7:0]       din;
   logic             thre;
   logic             baud_pulse;
   logic             temt;
   logic             full;
   logic [4:0]       count;
   logic             ovf;
   logic             thre_int;

   int pass_cnt  = 0;
   int total_cnt = 0;
   logic [7:0] exp_q [$];

   uart_tx_sched #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
      .fifo_clr(fifo_clr), .divisor(divisor), .div_ld(div_ld), .pop(pop),
      .sreg_empty(sreg_empty), .din(din), .thre(thre), .baud_pulse(baud_pulse),
      .temt(temt), .full(full), .count(count), .ovf(ovf), .thre_int(thre_int)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total_cnt++;
      if (actual === expected)
         pass_cnt++;
      else
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Inputs change 1ns after an edge, are consumed by the next edge, then drop.
   task automatic applyStimulus(input logic we, input logic [7:0] data,
                                input logic p, input logic clr);
      wr_en    = we;
      wr_data  = data;
      pop      = p;
      fifo_clr = clr;
      if (clr)
         exp_q.delete();
      else if (we && exp_q.size() < DEPTH)
         exp_q.push_back(data);
      cycle();
      wr_en    = 1'b0;
      pop      = 1'b0;
      fifo_clr = 1'b0;
   endtask

   // The byte on din at the negedge before an effective pop must be the queue head.
   always @(negedge clk) begin
      if (rst && pop && !thre) begin
         if (exp_q.size() == 0)
            checkOutput("pop_unexpected", 32'(din), 32'hFFFF_FFFF);
         else
            checkOutput("pop_data", 32'(din), 32'(exp_q.pop_front()));
      end
   end

   initial begin
      int pulses;
      rst = 1'b0; wr_en = 1'b0; wr_data = '0; fifo_clr = 1'b0;
      divisor = '0; div_ld = 1'b0; pop = 1'b0; sreg_empty = 1'b1;
      repeat (3) cycle();
      rst = 1'b1;
      cycle();

      // Reset and idle
      checkOutput("rst_thre",  32'(thre),  32'd1);
      checkOutput("rst_temt",  32'(temt),  32'd1);
      checkOutput("rst_count", 32'(count), 32'd0);
      checkOutput("rst_din",   32'(din),   32'd0);
      checkOutput("rst_full",  32'(full),  32'd0);
      checkOutput("rst_ovf",   32'(ovf),   32'd0);
      pulses = 0;
      for (int i = 0; i < 100; i++) begin
         cycle();
         if (baud_pulse) pulses++;
      end
      checkOutput("idle_baud_pulses", 32'(pulses), 32'd0);

      // Single byte
      applyStimulus(1'b1, 8'h13, 1'b0, 1'b0);
      checkOutput("single_din",   32'(din),   32'h13);
      checkOutput("single_thre",  32'(thre),  32'd0);
      checkOutput("single_count", 32'(count), 32'd1);
      repeat (2) cycle();
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("single_thre_after",  32'(thre),     32'd1);
      checkOutput("single_thre_int",    32'(thre_int), 32'd1);
      checkOutput("single_count_after", 32'(count),    32'd0);
      checkOutput("single_din_after",   32'(din),      32'd0);
      cycle();
      checkOutput("single_thre_int_off", 32'(thre_int), 32'd0);

      // Fill, overflow, drain, then refill across the pointer wrap
      for (int i = 0; i < 16; i++)
         applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
      checkOutput("fill_full",  32'(full),  32'd1);
      checkOutput("fill_count", 32'(count), 32'd16);
      checkOutput("fill_ovf",   32'(ovf),   32'd0);
      applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0);
      checkOutput("ovf_set",   32'(ovf),   32'd1);
      checkOutput("ovf_count", 32'(count), 32'd15);
      for (int i = 0; i < 15; i++)
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("drain_thre", 32'(thre), 32'd1);
      checkOutput("drain_ovf_sticky", 32'(ovf), 32'd1);
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 10; i++)
            applyStimulus(1'b1, 8'(8'h40 + 8'(r * 16) + 8'(i)), 1'b0, 1'b0);
         checkOutput("wrap_count", 32'(count), 32'd10);
         for (int i = 0; i < 10; i++)
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      end
      checkOutput("wrap_empty", 32'(count), 32'd0);

      // Simultaneous push and pop at count 1
      applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0);
      checkOutput("pp_count",    32'(count),    32'd1);
      checkOutput("pp_din",      32'(din),      32'h5A);
      checkOutput("pp_thre_int", 32'(thre_int), 32'd0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("pp_drain_int", 32'(thre_int), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("empty_pop_count", 32'(count),    32'd0);
      checkOutput("empty_pop_int",   32'(thre_int), 32'd0);
      checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

      // Baud: period 6, then 3 after the next reload, then constant 1, then frozen
      divisor = 16'd6; div_ld = 1'b1;
      cycle();
      div_ld = 1'b0;
      for (int k = 1; k <= 36; k++) begin
         cycle();
         checkOutput($sformatf("baud_k%0d", k), 32'(baud_pulse),
                     32'((k <= 30) ? (k % 6 == 0) : ((k - 30) % 3 == 0)));
         if (k == 24) divisor = 16'd3;
      end
      divisor = 16'd1; div_ld = 1'b1;
      cycle();
      div_ld = 1'b0;
      checkOutput("baud_ld_quiet", 32'(baud_pulse), 32'd0);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         if (baud_pulse) pulses++;
      end
      checkOutput("baud_div1_const", 32'(pulses), 32'd8);
      divisor = '0;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         if (baud_pulse) pulses++;
      end
      checkOutput("baud_div0_off", 32'(pulses), 32'd0);

      // temt follows sreg_empty combinationally
      sreg_empty = 1'b0;
      #1;
      checkOutput("temt_busy", 32'(temt), 32'd0);
      sreg_empty = 1'b1;
      #1;
      checkOutput("temt_idle", 32'(temt), 32'd1);

      // Flush with a concurrent write, then asynchronous reset mid-operation
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b1, 8'(8'h60 + 8'(i)), 1'b0, 1'b0);
      checkOutput("clr_pre_count", 32'(count), 32'd5);
      checkOutput("clr_pre_ovf",   32'(ovf),   32'd1);
      applyStimulus(1'b1, 8'h77, 1'b0, 1'b1);
      checkOutput("clr_count",    32'(count),    32'd0);
      checkOutput("clr_thre",     32'(thre),     32'd1);
      checkOutput("clr_ovf",      32'(ovf),      32'd0);
      checkOutput("clr_thre_int", 32'(thre_int), 32'd0);
      cycle();
      checkOutput("clr_thre_int_late", 32'(thre_int), 32'd0);

      divisor = 16'd1; div_ld = 1'b1;
      cycle();
      div_ld = 1'b0;
      applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'hBB, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'hCC, 1'b0, 1'b0);
      checkOutput("pre_rst_count", 32'(count),      32'd3);
      checkOutput("pre_rst_din",   32'(din),        32'hAA);
      checkOutput("pre_rst_baud",  32'(baud_pulse), 32'd1);
      #1 rst = 1'b0;
      #1;
      exp_q.delete();
      checkOutput("async_count", 32'(count),      32'd0);
      checkOutput("async_thre",  32'(thre),       32'd1);
      checkOutput("async_din",   32'(din),        32'd0);
      checkOutput("async_full",  32'(full),       32'd0);
      checkOutput("async_baud",  32'(baud_pulse), 32'd0);
      checkOutput("async_temt",  32'(temt),       32'd1);
      checkOutput("async_int",   32'(thre_int),   32'd0);
      divisor = '0;
      cycle();
      rst = 1'b1;
      cycle();
      checkOutput("post_rst_thre", 32'(thre), 32'd1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit-side controller for the UART transmitter datapath. It buffers host bytes in a TX FIFO, presents the head byte and the `thre` (holding-register-empty) flag to the transmitter, consumes entries on the transmitter's `pop`, and generates the `baud_pulse` tick from a programmable divisor. It sits between the register/bus interface and the transmitter core, replacing the single holding register with 16550-style FIFO mode.

## Interface

**Parameters**
- `DEPTH`, default 16: FIFO entries; must be a power of two, at least 2.
- `DIV_W`, default 16: divisor width.

**Ports**
- `clk`, input, 1: system clock; all logic runs on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `wr_en`, input, 1: host write strobe; pushes `wr_data`.
- `wr_data`, input, 8: byte to transmit.
- `fifo_clr`, input, 1: synchronous FIFO flush.
- `divisor`, input, DIV_W: baud divisor, in clk cycles per baud tick.
- `div_ld`, input, 1: reload the baud counter from `divisor`.
- `pop`, input, 1: transmitter has consumed `din`.
- `sreg_empty`, input, 1: the transmitter shift register is idle.
- `din`, output, 8: FIFO head byte sent to the transmitter.
- `thre`, output, 1: FIFO empty.
- `baud_pulse`, output, 1: one-cycle baud tick.
- `temt`, output, 1: transmitter fully empty (`thre & sreg_empty`).
- `full`, output, 1: FIFO holds DEPTH entries.
- `count`, output, log2(DEPTH)+1: number of FIFO entries.
- `ovf`, output, 1: sticky flag set by a write attempted while full.
- `thre_int`, output, 1: one-cycle pulse when the FIFO becomes empty.

## Operation

**FIFO**
- Storage is circular: `wr_ptr` and `rd_ptr` are log2(DEPTH) bits and wrap from DEPTH-1 to 0.
- `count` is a separate register.
- Push condition: `wr_en & ~full`.
- Pop condition: `pop & ~thre`.
  - A pop while empty is ignored; `count` never underflows.
- Push and pop in the same cycle: both take effect and `count` is unchanged.
- When full, a push is rejected even if a pop occurs in the same cycle. `ovf` is set.
- `fifo_clr`:
  - Zeroes both pointers and `count`, and clears `ovf`.
  - Overrides any push or pop in the same cycle.
  - Does not fire `thre_int`.
- `din` is `mem[rd_ptr]` when `count != 0`, otherwise 8'h00. FIFO memory is not reset.
- `thre` is `count == 0`. `full` is `count == DEPTH`.
- `thre_int` pulses for one cycle in the cycle after a pop takes `count` from 1 to 0.
  - It does not pulse if a push in the same cycle keeps `count` at 1.

**Baud generator**
- A down-counter `bcnt` (DIV_W bits) runs as follows:
  - If `divisor == 0`: `bcnt` holds and `baud_pulse` stays 0.
  - Else if `div_ld`: `bcnt <= divisor`, and no pulse occurs that cycle.
  - Else if `bcnt <= 1`: `baud_pulse <= 1` and `bcnt <= divisor`.
  - Else: `bcnt <= bcnt - 1` and `baud_pulse <= 0`.
- Steady-state pulse period is exactly `divisor` clk cycles. With `divisor == 1`, `baud_pulse` is high continuously.
- Changing `divisor` without `div_ld` takes effect at the next reload.

**Reset** (`rst` low, asynchronous)
- Pointers, `count`, `ovf`, `thre_int`, `baud_pulse` and `bcnt` go to 0.
- Consequently `thre=1`, `full=0`, `din=8'h00`, and `temt=sreg_empty`.

## Timing

- Write to `din` latency: a byte written at edge N appears on `din`, with `thre` falling, after edge N when the FIFO was empty (one registered stage).
- Pop: `pop` sampled at edge N advances `din` to the next entry after edge N. `thre` rises after edge N if that was the last entry, and `thre_int` is high for the cycle following edge N.
- `ovf` asserts the cycle after the rejected write and remains set until `fifo_clr` or reset.
- First `baud_pulse` after `div_ld` at edge N occurs at edge N+`divisor`; it is high for one cycle, except when `divisor == 1`.
- Reset asserted mid-transfer clears the FIFO immediately. The transmitter sees `thre=1` with no extra pop required.
- `temt` is combinational from `thre` and `sreg_empty`; there is no added latency.

## Test plan

1. **Reset and idle.** Release `rst`; leave `divisor=0`, drive no writes. Required: `thre=1`, `temt=1` (with `sreg_empty=1`), `count=0`, `din=0`, and `baud_pulse` stays 0 for 100 cycles.
2. **Single byte.** Write 8'h13, then pulse `pop` once after 3 cycles. Required: `din=8'h13` and `thre=0` the cycle after the write; after the pop, `thre=1`, a one-cycle `thre_int`, and `count` back to 0.
3. **Fill and overflow.** Write 8'h00–8'h0F, then 8'hFF. Required: `full=1` and `count=16`; the 8'hFF write is dropped and `ovf=1`. Sixteen pops return 8'h00–8'h0F in order, with pointer wrap on a second fill.
4. **Simultaneous push and pop.** With `count=1` (8'hA5 at the head), assert `wr_en` (8'h5A) and `pop` in the same cycle. Required: `count` stays 1, `din=8'h5A`, and no `thre_int`.
5. **Baud divisor.** Set `divisor=6` with `div_ld`. Required: pulses exactly every 6 cycles, each one cycle wide. Change to 3 without `div_ld`: the new period starts after the next pulse. `divisor=1` gives a constant 1.
6. **Clear and reset mid-operation.** Assert `fifo_clr` together with `wr_en` at `count=5`. Required: `count=0`, `thre=1`, `ovf=0`, and no `thre_int`. Then load 3 bytes and drop `rst` asynchronously between edges: all outputs go to their reset values before the next edge.
